// File: rtl/pipelined_scaled_multiplier.sv
// Multi-lane signed multiplier with an arithmetic right shift, optional round-half-up and
// optional saturation. Valid/ready pipeline that stalls every stage at once.
module pipelined_scaled_multiplier #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SCALE = 8,
  parameter int LANES     = 4,
  parameter int STAGES    = 2
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic [LANES*A_WIDTH-1:0]     a_in,
  input  logic [LANES*B_WIDTH-1:0]     b_in,
  input  logic                         round_en_in,
  input  logic                         sat_en_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out,
  output logic [LANES-1:0]             out_sat,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int PW = A_WIDTH + B_WIDTH;
  // One guard bit so that adding the rounding constant can never overflow.
  localparam int RW = PW + 1;
  localparam int CW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;

  localparam logic signed [RW-1:0] HALF = RW'((2 ** OUT_SCALE) / 2);
  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic en;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  function automatic logic signed [RW-1:0] prod_round(
    input logic signed [A_WIDTH-1:0] a,
    input logic signed [B_WIDTH-1:0] b,
    input logic                      rnd
  );
    logic signed [RW-1:0] ax;
    logic signed [RW-1:0] bx;
    logic signed [RW-1:0] p;
    ax = {{(RW-A_WIDTH){a[A_WIDTH-1]}}, a};
    bx = {{(RW-B_WIDTH){b[B_WIDTH-1]}}, b};
    p  = ax * bx;
    if (rnd) p = p + HALF;
    return p;
  endfunction

  // Returns {overflow, result}; overflow is reported whether or not saturation is on.
  function automatic logic [OUT_WIDTH:0] shift_sat(
    input logic signed [RW-1:0] r,
    input logic                 sat
  );
    logic signed [RW-1:0]  s;
    logic signed [CW-1:0]  sx;
    logic                  ovf_hi;
    logic                  ovf_lo;
    logic [OUT_WIDTH-1:0]  res;
    s      = r >>> OUT_SCALE;
    sx     = {{(CW-RW){s[RW-1]}}, s};
    ovf_hi = sx > MAXV;
    ovf_lo = sx < MINV;
    if (sat && ovf_hi)      res = MAXV[OUT_WIDTH-1:0];
    else if (sat && ovf_lo) res = MINV[OUT_WIDTH-1:0];
    else                    res = sx[OUT_WIDTH-1:0];
    return {ovf_hi | ovf_lo, res};
  endfunction

  logic [LANES*RW-1:0] r_in;

  always_comb begin
    r_in = '0;
    for (int i = 0; i < LANES; i++) begin
      r_in[i*RW +: RW] = prod_round(a_in[i*A_WIDTH +: A_WIDTH],
                                    b_in[i*B_WIDTH +: B_WIDTH], round_en_in);
    end
  end

  logic [LANES*RW-1:0] fin_r;
  logic                fin_sat;
  logic                fin_valid;

  generate
    if (STAGES == 1) begin : g_single
      assign fin_r     = r_in;
      assign fin_sat   = sat_en_in;
      assign fin_valid = in_valid;
    end else begin : g_multi
      logic [LANES*RW-1:0] mid_r [STAGES-1];
      logic [STAGES-2:0]   mid_sat;
      logic [STAGES-2:0]   mid_valid;

      always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
          mid_sat   <= '0;
          mid_valid <= '0;
          for (int k = 0; k < STAGES-1; k++) mid_r[k] <= '0;
        end else if (en) begin
          mid_r[0]     <= r_in;
          mid_sat[0]   <= sat_en_in;
          mid_valid[0] <= in_valid;
          for (int k = 1; k < STAGES-1; k++) begin
            mid_r[k]     <= mid_r[k-1];
            mid_sat[k]   <= mid_sat[k-1];
            mid_valid[k] <= mid_valid[k-1];
          end
        end
      end

      assign fin_r     = mid_r[STAGES-2];
      assign fin_sat   = mid_sat[STAGES-2];
      assign fin_valid = mid_valid[STAGES-2];
    end
  endgenerate

  logic [LANES*OUT_WIDTH-1:0] res_next;
  logic [LANES-1:0]           ovf_next;

  always_comb begin
    res_next = '0;
    ovf_next = '0;
    for (int i = 0; i < LANES; i++) begin
      {ovf_next[i], res_next[i*OUT_WIDTH +: OUT_WIDTH]} = shift_sat(fin_r[i*RW +: RW], fin_sat);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      out       <= '0;
      out_sat   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out       <= res_next;
      out_sat   <= ovf_next;
      out_valid <= fin_valid;
    end
  end

endmodule

// File: tb/tb_pipelined_scaled_multiplier.sv
// Bench for pipelined_scaled_multiplier: three parameterisations share one stimulus stream
// and are checked each cycle against an arithmetic beat model plus literal expectations.
module tb_pipelined_scaled_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic [31:0] a_in, b_in;
  logic        round_en, sat_en, in_valid, out_ready;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [63:0] out0, out2;
  logic [31:0] out1;
  logic [3:0]  sat0, sat1, sat2;

  pipelined_scaled_multiplier dut0 (
    .clk(clk), .arst_n_in(arst_n), .a_in(a_in), .b_in(b_in), .round_en_in(round_en),
    .sat_en_in(sat_en), .in_valid(in_valid), .in_ready(ir0), .out(out0), .out_sat(sat0),
    .out_valid(ov0), .out_ready(out_ready));

  pipelined_scaled_multiplier #(.OUT_WIDTH(8), .OUT_SCALE(4)) dut1 (
    .clk(clk), .arst_n_in(arst_n), .a_in(a_in), .b_in(b_in), .round_en_in(round_en),
    .sat_en_in(sat_en), .in_valid(in_valid), .in_ready(ir1), .out(out1), .out_sat(sat1),
    .out_valid(ov1), .out_ready(out_ready));

  pipelined_scaled_multiplier #(.OUT_SCALE(2)) dut2 (
    .clk(clk), .arst_n_in(arst_n), .a_in(a_in), .b_in(b_in), .round_en_in(round_en),
    .sat_en_in(sat_en), .in_valid(in_valid), .in_ready(ir2), .out(out2), .out_sat(sat2),
    .out_valid(ov2), .out_ready(out_ready));

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
    logic [31:0] r;
    r = {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    return r;
  endfunction

  // Plain integer arithmetic: product, optional +half, floor shift, clamp or wrap.
  function automatic void lane_model(input int a, input int b, input logic rnd, input logic sat,
                                     input int scale, input int ow,
                                     output logic [15:0] res, output logic ovf);
    longint p, s, mx, mn, w;
    p = longint'(a) * longint'(b);
    if (rnd && scale > 0) p = p + (longint'(1) << (scale - 1));
    s  = p >>> scale;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    ovf = (s > mx) || (s < mn);
    if (sat && s > mx)      w = mx;
    else if (sat && s < mn) w = mn;
    else                    w = s;
    res = w[15:0];
  endfunction

  typedef struct packed {
    logic        v;
    logic [63:0] o0;
    logic [3:0]  s0;
    logic [31:0] o1;
    logic [3:0]  s1;
    logic [63:0] o2;
    logic [3:0]  s2;
  } beat_t;

  function automatic beat_t make_beat(input logic v, input logic [31:0] a, input logic [31:0] b,
                                      input logic rnd, input logic sat);
    beat_t       bt;
    logic [15:0] r;
    logic        f;
    int          ai, bi;
    bt   = '0;
    bt.v = v;
    for (int i = 0; i < 4; i++) begin
      ai = int'($signed(a[i*8 +: 8]));
      bi = int'($signed(b[i*8 +: 8]));
      lane_model(ai, bi, rnd, sat, 8, 16, r, f);
      bt.o0[i*16 +: 16] = r;
      bt.s0[i] = f;
      lane_model(ai, bi, rnd, sat, 4, 8, r, f);
      bt.o1[i*8 +: 8] = r[7:0];
      bt.s1[i] = f;
      lane_model(ai, bi, rnd, sat, 2, 16, r, f);
      bt.o2[i*16 +: 16] = r;
      bt.s2[i] = f;
    end
    return bt;
  endfunction

  // Two-deep beat model: a beat moves on whenever the output slot is empty or being taken.
  beat_t slot0, slot1;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (!slot1.v || out_ready) begin
      slot1 <= slot0;
      slot0 <= make_beat(in_valid, a_in, b_in, round_en, sat_en);
    end
  end

  logic        prev_stall = 1'b0;
  logic [63:0] prev0;
  logic [31:0] prev1;

  always @(negedge clk) begin
    if (!arst_n) begin
      prev_stall <= 1'b0;
    end else begin
      chk("out_valid", 64'({ov0, ov1, ov2}), 64'({3{slot1.v}}));
      chk("in_ready", 64'({ir0, ir1, ir2}), 64'({3{!slot1.v || out_ready}}));
      if (slot1.v) begin
        chk("out_w16s8", out0, slot1.o0);
        chk("sat_w16s8", 64'(sat0), 64'(slot1.s0));
        chk("out_w8s4", 64'(out1), 64'(slot1.o1));
        chk("sat_w8s4", 64'(sat1), 64'(slot1.s1));
        chk("out_w16s2", out2, slot1.o2);
        chk("sat_w16s2", 64'(sat2), 64'(slot1.s2));
      end
      if (prev_stall) begin
        chk("hold_w16s8", out0, prev0);
        chk("hold_w8s4", 64'(out1), 64'(prev1));
      end
      prev_stall <= ov0 && !out_ready;
      prev0      <= out0;
      prev1      <= out1;
      if (ov0 && out_ready) n_out <= n_out + 1;
    end
  end

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                          input logic sat);
    @(posedge clk); #1;
    a_in = a; b_in = b; round_en = rnd; sat_en = sat; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("send_in_ready", 64'(ir0), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("send_lat1", 64'(ov0), 64'd0);
    @(negedge clk);
    chk("send_lat2", 64'(ov0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  int sent, acc, n0;

  initial begin
    arst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; round_en = 1'b0; sat_en = 1'b0;
    #2;
    chk("rst_out_valid", 64'({ov0, ov1, ov2}), '0);
    chk("rst_out", out0 | out2 | 64'(out1), '0);
    chk("rst_sat", 64'({sat0, sat1, sat2}), '0);
    #10 arst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(ir0), 64'd1);

    send_one(pk(100, -128, 127, -128), pk(100, -128, 127, 127), 1'b0, 1'b1);
    chk("lit_100x100", 64'(out0[15:0]), 64'd39);
    chk("lit_m128sq", 64'(out0[31:16]), 64'd64);
    chk("lit_sat0", 64'(sat0), 64'd0);
    chk("lit_w8_max", 64'(out1[23:16]), 64'h7F);
    chk("lit_w8_min", 64'(out1[31:24]), 64'h80);
    chk("lit_w8_flags", 64'(sat1[3:2]), 64'd3);

    send_one(pk(100, -128, 127, -128), pk(100, -128, 127, 127), 1'b0, 1'b0);
    chk("lit_w8_wrap", 64'(out1[23:16]), 64'hF0);
    chk("lit_w8_wrapflag", 64'(sat1[2]), 64'd1);

    send_one(pk(3, -2, 2, 0), pk(-3, 3, 3, 0), 1'b0, 1'b0);
    chk("lit_s2_trunc_a", 64'(out2[15:0]), 64'hFFFD);
    chk("lit_s2_trunc_b", 64'(out2[31:16]), 64'hFFFE);

    send_one(pk(3, -2, 2, 0), pk(-3, 3, 3, 0), 1'b1, 1'b0);
    chk("lit_s2_round_a", 64'(out2[15:0]), 64'hFFFE);
    chk("lit_s2_round_b", 64'(out2[31:16]), 64'hFFFF);
    chk("lit_s2_round_c", 64'(out2[47:32]), 64'd2);

    // Back-pressure: six beats, output blocked for cycles 3..5.
    @(posedge clk); #1;
    n0 = n_out; sent = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      out_ready = !(k >= 3 && k <= 5);
      if (sent < 6) begin
        a_in = pk(sent*10 + 1, -sent - 1, sent*20, 5);
        b_in = pk(50, 100, -sent*7 - 3, -sent);
        round_en = sent[0]; sat_en = sent[1]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k == 4) chk("bp_stall_ready", 64'(ir0), 64'd0);
      if (in_valid && ir0) sent++;
    end
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_out_count", 64'(n_out - n0), 64'd6);

    // Full throughput with the mode changing on every beat.
    out_ready = 1'b1;
    n0 = n_out; acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      a_in = pk(k*13 - 100, k*7, -k*11, 127 - k);
      b_in = pk(k*5 + 1, -k*9, 3*k - 30, -128 + k);
      round_en = k[0]; sat_en = k[1]; in_valid = 1'b1;
      #1 if (ir0) acc++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("tp_accepted", 64'(acc), 64'd20);
    chk("tp_out_count", 64'(n_out - n0), 64'd20);

    // Reset with two beats in flight, asserted and released between clock edges.
    @(posedge clk); #1;
    a_in = pk(1, 2, 3, 4); b_in = pk(5, 6, 7, 8); in_valid = 1'b1;
    @(posedge clk); #1;
    a_in = pk(-9, 10, -11, 12); b_in = pk(13, -14, 15, -16);
    @(posedge clk); #1 in_valid = 1'b0;
    #2 chk("pre_rst_valid", 64'(ov0), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'({ov0, ov1, ov2}), '0);
    chk("mid_rst_out", out0 | out2 | 64'(out1), '0);
    chk("mid_rst_sat", 64'({sat0, sat1, sat2}), '0);
    @(posedge clk); #4 arst_n = 1'b1;
    send_one(pk(100, -128, 0, 0), pk(100, -128, 0, 0), 1'b0, 1'b0);
    chk("post_rst_first", 64'(out0[31:0]), 64'({16'd64, 16'd39}));
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
